// File: rtl/nlo_pkg.sv
// Shared definitions for the non-linear-unit feeder: op encodings, FSM states
// and configuration register addresses.
package nlo_pkg;

  typedef enum logic [2:0] {
    OP_EXP        = 3'd0,
    OP_GELU       = 3'd1,
    OP_LAYER_NORM = 3'd2,
    OP_REQUANT    = 3'd3,
    OP_SOFTMAX    = 3'd4
  } nlo_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } feeder_state_e;

  localparam logic [3:0] CFG_OP       = 4'd0;
  localparam logic [3:0] CFG_QB       = 4'd1;
  localparam logic [3:0] CFG_QC       = 4'd2;
  localparam logic [3:0] CFG_QLN2     = 4'd3;
  localparam logic [3:0] CFG_QLN2_INV = 4'd4;
  localparam logic [3:0] CFG_FP_BITS  = 4'd5;
  localparam logic [3:0] CFG_Q1       = 4'd6;
  localparam logic [3:0] CFG_SHIFT    = 4'd7;
  localparam logic [3:0] CFG_BIAS     = 4'd8;
  localparam logic [3:0] CFG_N_INV    = 4'd9;
  localparam logic [3:0] CFG_MAX_BITS = 4'd10;
  localparam logic [3:0] CFG_M        = 4'd11;
  localparam logic [3:0] CFG_OUT_BITS = 4'd12;
  localparam logic [3:0] CFG_SREQ     = 4'd13;
  localparam logic [3:0] CFG_E        = 4'd14;
  localparam logic [3:0] CFG_CLR_ERR  = 4'd15;

  // Coefficients at addresses 1..13 are stored contiguously, index = addr - 1.
  localparam int unsigned NUM_COEF = 13;

endpackage

// File: rtl/nlo_feeder_if.sv
// Valid/ready data stream used for the sample input and the result output.
interface nlo_feeder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/nlo_result_fifo.sv
// Small synchronous FIFO holding non-linear-unit results until the consumer
// takes them; simultaneous push and pop keep count and order.
module nlo_result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nlo_feeder.sv
// Feeds one sample at a time plus frozen coefficients to the non-linear unit,
// waits for a trustworthy result (or times out) and queues results downstream.
module nlo_feeder
  import nlo_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MIN_HOLD = 9,
  parameter int unsigned TIMEOUT  = 63,
  parameter int unsigned DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  nlo_feeder_if.slave      s,
  nlo_feeder_if.master     m,
  output logic [2:0]       nlo_op,
  output logic             nlo_in_valid,
  output logic [WIDTH-1:0] nlo_qin,
  output logic [WIDTH-1:0] nlo_qb,
  output logic [WIDTH-1:0] nlo_qc,
  output logic [WIDTH-1:0] nlo_qln2,
  output logic [WIDTH-1:0] nlo_qln2_inv,
  output logic [WIDTH-1:0] nlo_fp_bits,
  output logic [WIDTH-1:0] nlo_q1,
  output logic [WIDTH-1:0] nlo_shift,
  output logic [WIDTH-1:0] nlo_bias,
  output logic [WIDTH-1:0] nlo_n_inv,
  output logic [WIDTH-1:0] nlo_max_bits,
  output logic [WIDTH-1:0] nlo_m,
  output logic [WIDTH-1:0] nlo_out_bits,
  output logic [WIDTH-1:0] nlo_sreq,
  output logic [7:0]       nlo_e,
  input  logic [WIDTH-1:0] nlo_qout,
  input  logic             nlo_out_valid,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned HW = $clog2(MIN_HOLD + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_HOLD);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  feeder_state_e    state_q, state_d;
  logic [HW-1:0]    hold_cnt;
  logic [TW-1:0]    wait_cnt;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             take, accept, abort;
  logic             hold_ok, timeout_hit;
  logic             cfg_live, clr_err;
  nlo_op_e          op_q;
  logic [WIDTH-1:0] coef_q [NUM_COEF];
  logic [7:0]       e_q;
  logic [WIDTH-1:0] qin_q;

  assign fifo_full   = (fifo_count == CW'(DEPTH));
  assign s.ready     = !reset && (state_q == ST_IDLE) && !fifo_full;
  assign hold_ok     = (hold_cnt == HOLD_MAX);
  // The wait counter holds TIMEOUT-1 during the last permitted WAIT cycle, so a
  // sample never occupies the unit for more than TIMEOUT cycles.
  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign cfg_live    = cfg_we && (state_q == ST_IDLE);
  assign clr_err     = cfg_we && (cfg_addr == CFG_CLR_ERR);

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    accept  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s.valid && s.ready) begin
          take    = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (hold_ok && nlo_out_valid) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || take) begin
      hold_cnt <= '0;
      wait_cnt <= '0;
    end else if (state_q == ST_WAIT) begin
      if (hold_cnt != HOLD_MAX)  hold_cnt <= hold_cnt + HW'(1);
      if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)     qin_q <= '0;
    else if (take) qin_q <= s.data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= OP_EXP;
      e_q  <= '0;
      for (int unsigned i = 0; i < NUM_COEF; i++) coef_q[i] <= '0;
    end else if (cfg_live) begin
      if (cfg_addr == CFG_OP)
        op_q <= nlo_op_e'(cfg_wdata[2:0]);
      else if (cfg_addr == CFG_E)
        e_q <= cfg_wdata[7:0];
      else if (cfg_addr != CFG_CLR_ERR)
        coef_q[cfg_addr - 4'd1] <= cfg_wdata;
    end
  end

  // A timeout in the same cycle as a clear request must not be lost.
  always_ff @(posedge clock) begin
    if (reset)        timeout_err <= 1'b0;
    else if (abort)   timeout_err <= 1'b1;
    else if (clr_err) timeout_err <= 1'b0;
  end

  nlo_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (nlo_qout),
    .pop       (m.valid && m.ready),
    .count     (fifo_count),
    .head      (m.data)
  );

  assign m.valid      = (fifo_count != '0);
  assign busy         = (state_q == ST_WAIT);
  assign nlo_in_valid = (state_q == ST_WAIT);
  assign nlo_qin      = qin_q;
  assign nlo_op       = op_q;
  assign nlo_e        = e_q;
  assign nlo_qb       = coef_q[0];
  assign nlo_qc       = coef_q[1];
  assign nlo_qln2     = coef_q[2];
  assign nlo_qln2_inv = coef_q[3];
  assign nlo_fp_bits  = coef_q[4];
  assign nlo_q1       = coef_q[5];
  assign nlo_shift    = coef_q[6];
  assign nlo_bias     = coef_q[7];
  assign nlo_n_inv    = coef_q[8];
  assign nlo_max_bits = coef_q[9];
  assign nlo_m        = coef_q[10];
  assign nlo_out_bits = coef_q[11];
  assign nlo_sreq     = coef_q[12];

endmodule
